fetch_queue: RTL
================

Name: fetch_queue

Overview:
Instruction prefetch buffer between the synchronous instruction memory and the fetch/decode pipeline register. It autonomously issues sequential word fetches and buffers up to DEPTH instructions, each with its PC+4. It presents them in order to the decode stage with a valid/ready handshake. A taken branch from decode (redirect) flushes all buffered and in-flight instructions and restarts fetching at the branch target.

Parameters:
DEPTH, 4, queue entries; power of two, >= 2
RESET_PC, 32'h0000_0000, first fetch address after reset; word aligned

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
imem_req  out  1  instruction memory read strobe; data is returned exactly one cycle later
imem_addr  out  32  byte address of the read; low 2 bits always 0
imem_rdata  in  32  read data, valid in the cycle after imem_req=1
redirect  in  1  taken branch from decode (PCSelect)
redirect_pc  in  32  branch target (BranchDir)
out_valid  out  1  head entry is valid
out_inst  out  32  head instruction
out_pc4  out  32  head instruction address + 4
out_ready  in  1  decode accepts the head entry; low means stall
count  out  $clog2(DEPTH)+1  number of occupied entries

Behaviour:
- Reset (synchronous, dominates every other input):
  - next state: fetch_pc=RESET_PC, count=0, inflight=0, queue empty.
  - Outputs during the reset cycle: imem_req=0, out_valid=0, out_inst=0, out_pc4=0.
- Issue:
  - imem_req=1 iff !reset && !redirect && (count + inflight) < DEPTH.
  - The same-cycle pop is ignored in this test (conservative credit check).
  - imem_addr=fetch_pc. On issue, fetch_pc <= fetch_pc+4, modulo 2^32.
  - inflight <= imem_req, and the issued address is captured for the response.
- Response:
  - In the cycle after an issue with inflight=1 and no redirect, imem_rdata is pushed at the tail.
  - The pushed entry's pc4 is the captured address + 4, modulo 2^32.
- Output:
  - out_valid = (count != 0) && !redirect.
  - out_inst/out_pc4 show the head entry combinationally; both are 0 when empty.
  - Pop occurs when out_valid && out_ready.
- Latency and throughput:
  - A request at cycle t responds at t+1 and is visible at the head at t+2.
  - Steady-state throughput is 1 instruction/cycle when out_ready=1 and DEPTH >= 3.
- Push and pop in the same cycle: count is unchanged and order is preserved. Pop when empty has no effect.
- Push when full cannot happen by construction of the credit rule. A simulation assertion fires if it does.
- Redirect (dominates push, pop and issue):
  - In the redirect cycle: no pop, no issue, the arriving response is discarded.
  - Next state: count=0, inflight=0, fetch_pc = {redirect_pc[31:2], 2'b00}.
  - The first fetch of the target is issued in the cycle after the redirect.
  - No entry fetched before the redirect ever appears at the output afterwards.
- Redirect held for consecutive cycles: the last cycle's redirect_pc wins.
- Reset in the middle of operation (full queue, inflight=1): everything is discarded. Fetching restarts at RESET_PC in the first cycle after reset.
- count always equals pushes minus pops since the last reset/redirect, and never exceeds DEPTH.

Test Plan:
1. Streaming. Release reset with out_ready=1 and imem_rdata = addr ^ 32'hA5A5_0000.
   - Addresses are 0,4,8,...
   - out_valid goes high at cycle 2 after release.
   - Outputs: out_inst = 32'hA5A5_0000 with out_pc4=4, then 32'hA5A5_0004 with out_pc4=8, and so on, with no bubbles.
2. Stall. Hold out_ready=0 from reset.
   - Exactly 4 requests issue (0,4,8,C); count settles at 4; imem_req stays 0.
   - Raise out_ready: outputs appear in order 0,4,8,C,10, and issue resumes.
3. Flush. With 3 entries queued plus one in flight, pulse redirect with redirect_pc=32'h100.
   - The next cycle has count=0 and issues 0x100.
   - The first accepted output has out_pc4=32'h104; no stale instruction ever appears.
4. Misaligned target. redirect_pc=32'h103 -> imem_addr=32'h100 -> out_pc4=32'h104.
5. Wrap-around. RESET_PC=32'hFFFF_FFF8 -> fetches FFFF_FFF8, FFFF_FFFC, 0000_0000.
   - The out_pc4 values are FFFF_FFFC, 0000_0000, 0000_0004.
6. Reset dominance.
   - Full queue, then assert reset together with redirect (redirect_pc=0x200): the next cycle has count=0 and out_valid=0, and the first fetch is at RESET_PC, not 0x200.

Source files
------------

// File: rtl/fetch_queue_if.sv
// fetch_queue_if
//   Groups the instruction-memory bus, the decode-side output handshake and
//   the redirect inputs of the prefetch queue.
//
//   Signals
//     imem_req     fetch strobe (queue -> memory)
//     imem_addr    word-aligned fetch address (queue -> memory)
//     imem_rdata   read data, one cycle after imem_req (memory -> queue)
//     redirect     taken branch from decode, flushes the queue
//     redirect_pc  branch target
//     out_valid    head entry valid (queue -> decode)
//     out_inst     head instruction
//     out_pc4      head instruction address + 4
//     out_ready    decode accepts head entry
//     count        occupied entries
//
//   Modports
//     master : the queue itself
//     slave  : the surrounding memory / decode logic
interface fetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          imem_req;
    logic [31:0]   imem_addr;
    logic [31:0]   imem_rdata;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          out_valid;
    logic [31:0]   out_inst;
    logic [31:0]   out_pc4;
    logic          out_ready;
    logic [CW-1:0] count;

    modport master (
        output imem_req, imem_addr, out_valid, out_inst, out_pc4, count,
        input  imem_rdata, redirect, redirect_pc, out_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_inst, out_pc4, count,
        output imem_rdata, redirect, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue
//   Instruction prefetch buffer between a synchronous instruction memory and
//   the fetch/decode pipeline register. Issues sequential word fetches on its
//   own, buffers up to DEPTH {instruction, pc+4} entries and presents them in
//   order. A redirect flushes everything, buffered and in flight, and restarts
//   fetching at the (word-aligned) target.
//
//   Ports
//     clk    rising-edge clock
//     reset  synchronous, active-high; dominates every other input
//     bus    fetch_queue_if.master (memory bus, decode handshake, redirect)
//
//   Handshake: an entry transfers on a rising edge where out_valid and
//   out_ready are both high. out_valid never depends on out_ready, and the
//   head entry is held stable while out_valid=1 and out_ready=0.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset,
    fetch_queue_if.master    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);

    logic [31:0]   inst_mem [DEPTH];
    logic [31:0]   pc4_mem  [DEPTH];
    logic [AW-1:0] head_q;
    logic [AW-1:0] tail_q;
    logic [CW-1:0] count_q;
    logic [31:0]   fetch_pc_q;
    logic [31:0]   inflight_addr_q;
    logic          inflight_q;

    logic          issue;
    logic          push;
    logic          pop;
    logic          empty;
    logic [CW:0]   credits_used;

    always_comb begin
        empty        = (count_q == '0);
        // The in-flight request already owns a slot; a pop in this same
        // cycle is deliberately not credited, keeping the check simple.
        credits_used = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
        issue        = !reset && !bus.redirect && (credits_used < DEPTH_W);
        push         = !reset && !bus.redirect && inflight_q;

        bus.imem_req  = issue;
        bus.imem_addr = fetch_pc_q;
        bus.out_valid = !reset && !bus.redirect && !empty;
        bus.out_inst  = (!reset && !empty) ? inst_mem[head_q] : 32'h0;
        bus.out_pc4   = (!reset && !empty) ? pc4_mem[head_q]  : 32'h0;
        bus.count     = count_q;

        pop           = bus.out_valid && bus.out_ready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q      <= RESET_PC;
            inflight_addr_q <= RESET_PC;
            inflight_q      <= 1'b0;
            count_q         <= '0;
            head_q          <= '0;
            tail_q          <= '0;
        end else if (bus.redirect) begin
            // Redirect wins over push, pop and issue; the response arriving
            // this cycle is simply dropped.
            fetch_pc_q <= {bus.redirect_pc[31:2], 2'b00};
            inflight_q <= 1'b0;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                inflight_addr_q <= fetch_pc_q;
                fetch_pc_q      <= fetch_pc_q + 32'd4;
            end
            if (push) tail_q <= tail_q + 1'b1;
            if (pop)  head_q <= head_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[tail_q] <= bus.imem_rdata;
            pc4_mem[tail_q]  <= inflight_addr_q + 32'd4;
        end
    end

    // The credit rule makes a push into a full queue impossible.
    assert property (@(posedge clk) disable iff (reset) push |-> (count_q != FULL))
        else $error("fetch_queue: push into full queue");
endmodule
